// File: rtl/vcpu_pkg.sv
// vcpu_pkg: shared state/owner encodings and bus constants for the vcpu memory arbiter.
package vcpu_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_ERR = 2'd3} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_DS = 1'b1} owner_e;
    localparam logic [3:0] BE_WORD = 4'hf;
    localparam int SYS_BITS = 32;
endpackage

// File: rtl/vcpu_arb_prio.sv
// vcpu_arb_prio: data-first owner pick with a saturating fetch-starvation counter.
module vcpu_arb_prio
    import vcpu_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   if_req_i,
    input  logic   ds_req_i,
    input  logic   pick_i,
    output owner_e owner_o,
    output logic   sat_o
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign sat_o   = cnt_q == CW'(STARVE_MAX);
    assign owner_o = (ds_req_i && !(if_req_i && sat_o)) ? OWN_DS : OWN_IF;
    always_comb begin
        cnt_d = !if_req_i ? '0 : !pick_i ? cnt_q : owner_o == OWN_IF ? '0 : sat_o ? cnt_q : cnt_q + CW'(1);
    end
    always_ff @(posedge clk_i) begin
        cnt_q <= rst_i ? '0 : cnt_d;
    end
endmodule

// File: rtl/vcpu_mem_arbiter.sv
// vcpu_mem_arbiter: shares the vcpu memory port between fetch and load/store, one transaction at a time.
// Defining VCPU_MISALIGN_TRAP_EN traps misaligned data accesses instead of issuing them.
module vcpu_mem_arbiter
    import vcpu_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                sck,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [15:0]         if_rdata,
    input  logic                ds_req,
    input  logic                ds_we,
    input  logic [ADDR_W-1:0]   ds_addr,
    input  logic [SYS_BITS-1:0] ds_wdata,
    output logic                ds_gnt,
    output logic                ds_rvalid,
    output logic [SYS_BITS-1:0] ds_rdata,
    output logic                ds_err,
    output logic                m_valid,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [SYS_BITS-1:0] m_wdata,
    output logic [3:0]          m_be,
    input  logic                m_ready,
    input  logic                m_rvalid,
    input  logic [SYS_BITS-1:0] m_rdata,
    output logic [3:0]          sta
);
    state_e              state_q, state_d;
    owner_e              owner_q, pick_own;
    logic                sat, pick, mis, we_q, half_q, rvalid_q;
    logic [ADDR_W-3:0]   addr_q;
    logic [SYS_BITS-1:0] wdata_q, rdata_q;
    logic                unused;

    assign pick   = state_q == ST_IDLE && (if_req || ds_req);
    assign unused = ^{if_addr[0], ds_addr[1:0]};

    vcpu_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk_i   (sck),
        .rst_i   (rst),
        .if_req_i(if_req),
        .ds_req_i(ds_req),
        .pick_i  (pick),
        .owner_o (pick_own),
        .sat_o   (sat)
    );

`ifdef VCPU_MISALIGN_TRAP_EN
    logic err_q;
    assign mis    = pick_own == OWN_DS && ds_addr[1:0] != 2'b00;
    assign ds_err = rvalid_q && err_q;
    always_ff @(posedge sck) begin
        err_q <= rst ? 1'b0 : state_q == ST_ERR;
    end
`else
    assign mis    = 1'b0;
    assign ds_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = !pick ? ST_IDLE : mis ? ST_ERR : ST_REQ;
            ST_REQ:  state_d = m_ready ? ST_WAIT : ST_REQ;
            ST_WAIT: state_d = m_rvalid ? ST_IDLE : ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_valid   = state_q == ST_REQ;
    assign m_we      = m_valid && we_q;
    assign m_addr    = {addr_q, 2'b00};
    assign m_wdata   = wdata_q;
    assign m_be      = BE_WORD;
    assign if_gnt    = m_valid && m_ready && owner_q == OWN_IF;
    assign ds_gnt    = ((m_valid && m_ready) || state_q == ST_ERR) && owner_q == OWN_DS;
    assign if_rvalid = rvalid_q && owner_q == OWN_IF;
    assign ds_rvalid = rvalid_q && owner_q == OWN_DS;
    assign if_rdata  = half_q ? rdata_q[31:16] : rdata_q[15:0];
    assign ds_rdata  = we_q ? '0 : rdata_q;
    assign sta       = {state_q, owner_q, sat};

    // Owner and payload are captured once at the pick so requesters may change inputs afterwards.
    always_ff @(posedge sck) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            half_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= (state_q == ST_WAIT && m_rvalid) || state_q == ST_ERR;
            if (state_q == ST_WAIT && m_rvalid) rdata_q <= m_rdata;
            else if (state_q == ST_ERR) rdata_q <= '0;
            if (pick) begin
                owner_q <= pick_own;
                we_q    <= pick_own == OWN_DS && ds_we;
                addr_q  <= pick_own == OWN_DS ? ds_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
                wdata_q <= ds_wdata;
                half_q  <= if_addr[1];
            end
        end
    end
endmodule
